// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command framer and its decoder:
// default frame marker bytes, FSM state encoding and a saturating counter helper.
package serial_cmd_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hFF;
  localparam logic [7:0] EOF_DEFAULT = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_READY   = 3'd2,
    ST_ACK     = 3'd3,
    ST_FLUSH   = 3'd4
  } state_t;

  // Byte counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Inter-byte idle timer for the command framer. Only present when
// SERIAL_CMD_FRAMER_TIMEOUT_EN is defined; the default build has no timer at all.
`ifdef SERIAL_CMD_FRAMER_TIMEOUT_EN
module byte_timeout_counter #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Idle-cycle count: cleared on every byte, advances while enabled, parks at expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    count <= '0;
    else if (restart)            count <= '0;
    else if (enable && !expired) count <= count + 1'b1;
  end

  // Expiry is flagged so the framer reacts on the LIMIT-th idle edge.
  always_comb begin
    expired = (count == CNT_W'(LIMIT - 1));
  end

endmodule
`endif

// File: rtl/serial_cmd_framer.sv
// Serial command framer: collects UART bytes between SOF and EOF markers into
// the downstream frame FIFO and handshakes completed frames with the decoder.
// Optional inter-byte timeout: define SERIAL_CMD_FRAMER_TIMEOUT_EN.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | hunting for SOF, other bytes silently discarded
//   COLLECT | pushing frame bytes until EOF, overlength or timeout
//   READY   | complete frame in FIFO, cmd_ready to decoder
//   ACK     | decoder done, acknowledge held until cmd_processed drops
//   FLUSH   | one-cycle FIFO clear, then back to IDLE
module serial_cmd_framer
  import serial_cmd_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE        = SOF_DEFAULT,
  parameter logic [7:0] EOF_BYTE        = EOF_DEFAULT,
  parameter int         MAX_FRAME_BYTES = 16,
  parameter int         TIMEOUT_CYCLES  = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_data,
  output logic       fifo_push,
  output logic [7:0] fifo_data,
  output logic       fifo_clear,
  output logic       cmd_ready,
  input  logic       cmd_processed,
  output logic       cmd_processed_received,
  output logic [7:0] frame_bytes,
  output logic       frame_error,
  output logic       rx_overrun
);

  generate
    if (MAX_FRAME_BYTES < 2 || MAX_FRAME_BYTES > 255) begin : g_bad_max
      $error("serial_cmd_framer: MAX_FRAME_BYTES must be in 2..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("serial_cmd_framer: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [7:0] MAX_B = 8'(MAX_FRAME_BYTES);

  state_t     state, state_next;
  logic       is_sof, is_eof, frame_full, timed_out;
  logic       push_d, err_d, overrun_d;
  logic [7:0] bytes_d;

  always_comb begin
    is_sof     = (rx_data == SOF_BYTE);
    is_eof     = (rx_data == EOF_BYTE);
    frame_full = (frame_bytes >= MAX_B);
  end

`ifdef SERIAL_CMD_FRAMER_TIMEOUT_EN
  logic to_enable, to_restart;

  // Timer only runs inside a frame and restarts on every received byte.
  always_comb begin
    to_enable  = (state == ST_COLLECT);
    to_restart = rx_data_valid || (state != ST_COLLECT);
  end

  byte_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (to_enable),
    .restart (to_restart),
    .expired (timed_out)
  );
`else
  // Without the timer a partial frame waits indefinitely for more bytes.
  always_comb begin
    timed_out = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (rx_data_valid && is_sof) state_next = ST_COLLECT;
      ST_COLLECT: begin
        if (rx_data_valid) begin
          if (frame_full)  state_next = ST_FLUSH;
          else if (is_eof) state_next = ST_READY;
        end else if (timed_out) begin
          state_next = ST_FLUSH;
        end
      end
      ST_READY:   if (cmd_ready && cmd_processed) state_next = ST_ACK;
      ST_ACK:     if (!cmd_processed) state_next = ST_FLUSH;
      ST_FLUSH:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output decode: Moore handshake outputs plus next values of the registered strobes.
  always_comb begin
    push_d    = 1'b0;
    err_d     = 1'b0;
    overrun_d = 1'b0;
    bytes_d   = frame_bytes;
    // cmd_ready waits until the EOF push has actually landed in the FIFO.
    cmd_ready              = (state == ST_READY) && !fifo_push;
    cmd_processed_received = (state == ST_ACK);
    fifo_clear             = (state == ST_FLUSH);
    case (state)
      ST_IDLE: begin
        if (rx_data_valid && is_sof) begin
          push_d  = 1'b1;
          bytes_d = 8'd1;
        end
      end
      ST_COLLECT: begin
        if (rx_data_valid) begin
          if (frame_full) begin
            err_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            bytes_d = sat_inc8(frame_bytes);
          end
        end else if (timed_out) begin
          err_d = 1'b1;
        end
      end
      ST_READY, ST_ACK, ST_FLUSH: overrun_d = rx_data_valid;
      default: ;
    endcase
  end

  // Registered strobes, FIFO data and frame byte count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_push   <= 1'b0;
      fifo_data   <= 8'h00;
      frame_bytes <= 8'h00;
      frame_error <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      fifo_push   <= push_d;
      if (push_d) fifo_data <= rx_data;
      frame_bytes <= bytes_d;
      frame_error <= err_d;
      rx_overrun  <= overrun_d;
    end
  end

endmodule

// File: tb/tb_serial_cmd_framer.sv
// Directed self-checking bench for serial_cmd_framer (MAX_FRAME_BYTES=16,
// TIMEOUT_CYCLES=100). Define SERIAL_CMD_FRAMER_TIMEOUT_EN to exercise the timeout.
module tb_serial_cmd_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_data_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_processed = 1'b0;
  logic       fifo_push, fifo_clear, cmd_ready, cmd_processed_received;
  logic       frame_error, rx_overrun;
  logic [7:0] fifo_data, frame_bytes;

  int checks = 0;
  int errors = 0;

  logic [7:0] push_q[$];
  int n_err = 0;
  int n_clr = 0;
  int n_ovr = 0;

  serial_cmd_framer #(
    .SOF_BYTE        (8'hFF),
    .EOF_BYTE        (8'hEE),
    .MAX_FRAME_BYTES (16),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rx_data_valid          (rx_data_valid),
    .rx_data                (rx_data),
    .fifo_push              (fifo_push),
    .fifo_data              (fifo_data),
    .fifo_clear             (fifo_clear),
    .cmd_ready              (cmd_ready),
    .cmd_processed          (cmd_processed),
    .cmd_processed_received (cmd_processed_received),
    .frame_bytes            (frame_bytes),
    .frame_error            (frame_error),
    .rx_overrun             (rx_overrun)
  );

  always #5 clk = ~clk;

  // Event log of everything the framer emits, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_push)   push_q.push_back(fifo_data);
    if (frame_error) n_err++;
    if (fifo_clear)  n_clr++;
    if (rx_overrun)  n_ovr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    @(posedge clk);
    push_q.delete();
    n_err = 0;
    n_clr = 0;
    n_ovr = 0;
  endtask

  // Returns at the negedge after the accepting edge, where the push strobe is visible.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data_valid = 1'b1;
    rx_data       = b;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic handshake();
    int k;
    @(negedge clk);
    cmd_processed = 1'b1;
    k = 0;
    while (cmd_processed_received !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (cmd_processed_received !== 1'b1) begin
      errors++;
      $display("FAIL handshake_ack: cmd_processed_received=%0b expected 1", cmd_processed_received);
    end
    cmd_processed = 1'b0;
    k = 0;
    while (fifo_clear !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (fifo_clear !== 1'b1) begin
      errors++;
      $display("FAIL handshake_clear: fifo_clear=%0b expected 1", fifo_clear);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({fifo_push, fifo_clear, cmd_ready, cmd_processed_received, frame_error, rx_overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {fifo_push, fifo_clear, cmd_ready, cmd_processed_received, frame_error, rx_overrun});
    end
    checks++;
    if (frame_bytes !== 8'd0) begin
      errors++;
      $display("FAIL reset_frame_bytes: got %0d expected 0", frame_bytes);
    end
    // SOF presented together with reset release must be taken on the first edge.
    rst           = 1'b1;
    rx_data_valid = 1'b1;
    rx_data       = 8'hFF;
    @(negedge clk);
    rx_data_valid = 1'b0;
    checks++;
    if (fifo_push !== 1'b1 || fifo_data !== 8'hFF || frame_bytes !== 8'd1) begin
      errors++;
      $display("FAIL first_edge_sof: push=%0b data=%h bytes=%0d expected 1 ff 1",
               fifo_push, fifo_data, frame_bytes);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (fifo_push !== 1'b0 || frame_bytes !== 8'd0 || fifo_clear !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: push=%0b bytes=%0d clear=%0b expected 0 0 0",
               fifo_push, frame_bytes, fifo_clear);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp [5] = '{8'hFF, 8'h01, 8'h20, 8'h02, 8'hEE};
    clear_log();
    for (int i = 0; i < 5; i++) begin
      send_byte(exp[i]);
      checks++;
      if (fifo_push !== 1'b1 || fifo_data !== exp[i]) begin
        errors++;
        $display("FAIL basic_push_latency[%0d]: push=%0b data=%h expected 1 %h", i, fifo_push, fifo_data, exp[i]);
      end
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_ready_early: cmd_ready=%0b expected 0 during EOF push", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || frame_bytes !== 8'd5) begin
      errors++;
      $display("FAIL basic_ready: cmd_ready=%0b bytes=%0d expected 1 5", cmd_ready, frame_bytes);
    end
    @(posedge clk);
    checks++;
    if (push_q.size() != 5) begin
      errors++;
      $display("FAIL basic_push_count: got %0d expected 5", push_q.size());
    end
    for (int i = 0; i < 5 && i < push_q.size(); i++) begin
      checks++;
      if (push_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_push_order[%0d]: got %h expected %h", i, push_q[i], exp[i]);
      end
    end
    handshake();
  endtask

  task automatic test_garbage_before_sof();
    logic [7:0] exp [3] = '{8'hFF, 8'h05, 8'hEE};
    clear_log();
    send_byte(8'h33);
    send_byte(8'h44);
    checks++;
    if (fifo_push !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL garbage_discard: push=%0b overrun=%0b expected 0 0", fifo_push, rx_overrun);
    end
    for (int i = 0; i < 3; i++) send_byte(exp[i]);
    repeat (2) @(posedge clk);
    checks++;
    if (push_q.size() != 3) begin
      errors++;
      $display("FAIL garbage_push_count: got %0d expected 3", push_q.size());
    end
    for (int i = 0; i < 3 && i < push_q.size(); i++) begin
      checks++;
      if (push_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL garbage_push_order[%0d]: got %h expected %h", i, push_q[i], exp[i]);
      end
    end
    checks++;
    if (cmd_ready !== 1'b1 || frame_bytes !== 8'd3) begin
      errors++;
      $display("FAIL garbage_ready: cmd_ready=%0b bytes=%0d expected 1 3", cmd_ready, frame_bytes);
    end
    handshake();
  endtask

  task automatic test_overlength();
    clear_log();
    send_byte(8'hFF);
    for (int i = 0; i < 15; i++) send_byte(8'h00);
    checks++;
    if (frame_bytes !== 8'd16 || fifo_push !== 1'b1) begin
      errors++;
      $display("FAIL overlength_full: bytes=%0d push=%0b expected 16 1", frame_bytes, fifo_push);
    end
    send_byte(8'h00);
    checks++;
    if (fifo_push !== 1'b0 || frame_error !== 1'b1 || fifo_clear !== 1'b1) begin
      errors++;
      $display("FAIL overlength_abort: push=%0b err=%0b clear=%0b expected 0 1 1",
               fifo_push, frame_error, fifo_clear);
    end
    @(negedge clk);
    checks++;
    if (frame_error !== 1'b0 || fifo_clear !== 1'b0 || cmd_ready !== 1'b0 || frame_bytes !== 8'd16) begin
      errors++;
      $display("FAIL overlength_pulse_width: err=%0b clear=%0b ready=%0b bytes=%0d expected 0 0 0 16",
               frame_error, fifo_clear, cmd_ready, frame_bytes);
    end
    // Back in IDLE, a non-SOF byte is dropped without overrun.
    send_byte(8'hEE);
    @(posedge clk);
    checks++;
    if (push_q.size() != 16 || n_ovr != 0 || n_err != 1 || n_clr != 1) begin
      errors++;
      $display("FAIL overlength_totals: pushes=%0d ovr=%0d err=%0d clr=%0d expected 16 0 1 1",
               push_q.size(), n_ovr, n_err, n_clr);
    end
  endtask

  task automatic test_ready_overrun_handshake();
    clear_log();
    send_byte(8'hFF);
    send_byte(8'hEE);
    @(negedge clk);
    send_byte(8'h55);
    checks++;
    if (fifo_push !== 1'b0 || rx_overrun !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_overrun: push=%0b overrun=%0b ready=%0b expected 0 1 1",
               fifo_push, rx_overrun, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ready_overrun_width: overrun=%0b expected 0", rx_overrun);
    end
    cmd_processed = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_processed_received !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ack_entry: ack=%0b ready=%0b expected 1 0", cmd_processed_received, cmd_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_processed_received !== 1'b1 || fifo_clear !== 1'b0) begin
      errors++;
      $display("FAIL ack_hold: ack=%0b clear=%0b expected 1 0", cmd_processed_received, fifo_clear);
    end
    cmd_processed = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_clear !== 1'b1 || cmd_processed_received !== 1'b0 || frame_bytes !== 8'd2) begin
      errors++;
      $display("FAIL flush_entry: clear=%0b ack=%0b bytes=%0d expected 1 0 2",
               fifo_clear, cmd_processed_received, frame_bytes);
    end
    @(negedge clk);
    checks++;
    if (fifo_clear !== 1'b0 || push_q.size() != 2) begin
      errors++;
      $display("FAIL flush_width: clear=%0b pushes=%0d expected 0 2", fifo_clear, push_q.size());
    end
  endtask

  task automatic test_timeout();
    int k;
    clear_log();
    send_byte(8'hFF);
    send_byte(8'h01);
`ifdef SERIAL_CMD_FRAMER_TIMEOUT_EN
    k = 0;
    while (frame_error !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (k != 100 || frame_error !== 1'b1 || fifo_clear !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cycle: cycles=%0d err=%0b clear=%0b expected 100 1 1", k, frame_error, fifo_clear);
    end
    @(negedge clk);
    checks++;
    if (frame_error !== 1'b0 || fifo_clear !== 1'b0 || frame_bytes !== 8'd2) begin
      errors++;
      $display("FAIL timeout_pulse: err=%0b clear=%0b bytes=%0d expected 0 0 2", frame_error, fifo_clear, frame_bytes);
    end
`else
    k = 0;
    repeat (1000) @(negedge clk);
    checks++;
    if (n_err != 0 || n_clr != 0 || cmd_ready !== 1'b0 || frame_bytes !== 8'd2) begin
      errors++;
      $display("FAIL no_timeout: err=%0d clr=%0d ready=%0b bytes=%0d expected 0 0 0 2",
               n_err, n_clr, cmd_ready, frame_bytes);
    end
    send_byte(8'hEE);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || frame_bytes !== 8'd3) begin
      errors++;
      $display("FAIL no_timeout_complete: ready=%0b bytes=%0d expected 1 3", cmd_ready, frame_bytes);
    end
    handshake();
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp [3] = '{8'hFF, 8'h02, 8'hEE};
    send_byte(8'hFF);
    send_byte(8'h01);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({fifo_push, fifo_clear, cmd_ready, frame_error, rx_overrun} !== 5'b0 || frame_bytes !== 8'd0) begin
      errors++;
      $display("FAIL mid_frame_reset: strobes=%b bytes=%0d expected 00000 0",
               {fifo_push, fifo_clear, cmd_ready, frame_error, rx_overrun}, frame_bytes);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    for (int i = 0; i < 3; i++) send_byte(exp[i]);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || frame_bytes !== 8'd3) begin
      errors++;
      $display("FAIL post_reset_frame: ready=%0b bytes=%0d expected 1 3", cmd_ready, frame_bytes);
    end
    @(posedge clk);
    checks++;
    if (push_q.size() != 3 || n_clr != 0) begin
      errors++;
      $display("FAIL post_reset_pushes: pushes=%0d clr=%0d expected 3 0", push_q.size(), n_clr);
    end
    for (int i = 0; i < 3 && i < push_q.size(); i++) begin
      checks++;
      if (push_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_order[%0d]: got %h expected %h", i, push_q[i], exp[i]);
      end
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3] = '{8'hFF, 8'h0A, 8'hEE};
    clear_log();
    @(negedge clk);
    rx_data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = exp[i];
      @(negedge clk);
    end
    rx_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (push_q.size() != 3 || frame_bytes !== 8'd3 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame: pushes=%0d bytes=%0d ready=%0b expected 3 3 1",
               push_q.size(), frame_bytes, cmd_ready);
    end
    for (int i = 0; i < 3 && i < push_q.size(); i++) begin
      checks++;
      if (push_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got %h expected %h", i, push_q[i], exp[i]);
      end
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_garbage_before_sof();
    test_overlength();
    test_ready_overrun_handshake();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_cmd_framer.md
SERIAL_CMD_FRAMER -- requirements
Module: serial_cmd_framer

Interface
REQ-001 Parameter SOF_BYTE, default 8'hFF: start-of-frame marker.
REQ-002 Parameter EOF_BYTE, default 8'hEE: end-of-frame marker.
REQ-003 Parameter MAX_FRAME_BYTES, default 16: max bytes per frame including SOF/EOF; equals downstream FIFO depth.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000: inter-byte idle limit in clk cycles (1 ms at 50 MHz).
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 rx_data_valid  in  1  one-cycle strobe per received UART byte.
REQ-008 rx_data  in  8  received byte, valid with rx_data_valid.
REQ-009 fifo_push  out  1  one-cycle push strobe to frame FIFO.
REQ-010 fifo_data  out  8  byte to FIFO, valid with fifo_push.
REQ-011 fifo_clear  out  1  one-cycle FIFO clear strobe.
REQ-012 cmd_ready  out  1  complete frame in FIFO, decoder may start.
REQ-013 cmd_processed  in  1  decoder finished (level, held until acknowledged).
REQ-014 cmd_processed_received  out  1  acknowledge to decoder.
REQ-015 frame_bytes  out  8  byte count of current/last frame incl. SOF/EOF.
REQ-016 frame_error  out  1  one-cycle pulse on overlength or timeout abort.
REQ-017 rx_overrun  out  1  one-cycle pulse when a byte is dropped during READY/ACK/FLUSH.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, READY, ACK, FLUSH.
REQ-019 IDLE: bytes other than SOF_BYTE discarded; SOF_BYTE pushed (same cycle registered, fifo_push next cycle), frame_bytes=1, -> COLLECT.
REQ-020 COLLECT: every byte pushed and frame_bytes incremented; EOF_BYTE pushed then -> READY.
REQ-021 COLLECT: a byte that would make frame_bytes exceed MAX_FRAME_BYTES is not pushed; frame_error pulses; -> FLUSH.
REQ-022 SOF_BYTE inside COLLECT is treated as payload (decoder rejects format).
REQ-023 READY: cmd_ready=1; on cmd_processed=1 -> ACK with cmd_ready=0.
REQ-024 ACK: cmd_processed_received=1 until cmd_processed=0, then -> FLUSH.
REQ-025 FLUSH: fifo_clear=1 exactly one cycle, frame_bytes held, -> IDLE.
REQ-026 Bytes arriving in READY, ACK or FLUSH are dropped and rx_overrun pulses one cycle later.
REQ-027 Push latency: fifo_push asserted exactly one cycle after accepted rx_data_valid; no two pushes for one strobe.
REQ-028 frame_bytes saturates arithmetic at 8 bits; MAX_FRAME_BYTES ≤ 255 enforced by parameter check.

Reset
REQ-029 On rst=0 all outputs 0, frame_bytes=0, timeout counter 0, state IDLE, regardless of state (mid-frame included); no fifo_clear issued by reset (FIFO has own clear).
REQ-030 First byte accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro SERIAL_CMD_FRAMER_TIMEOUT_EN defined: in COLLECT, counter reset on each rx_data_valid, increments otherwise; reaching TIMEOUT_CYCLES pulses frame_error and -> FLUSH.
REQ-032 Macro undefined: no counter logic; COLLECT waits indefinitely; TIMEOUT_CYCLES ignored.

Structure
REQ-033 Package serial_cmd_pkg SHALL hold SOF/EOF default byte constants and FSM state encodings, shared with serial_cmd_decoder.
REQ-034 Timeout counter SHALL be sub-module byte_timeout_counter (enable, restart, expired), instantiated only under the macro.

Verification
REQ-035 Bytes FF 01 20 02 EE -> five pushes in order, frame_bytes=5, cmd_ready=1 one cycle after EE push.
REQ-036 Bytes 33 44 then FF 05 EE -> 33/44 not pushed, three pushes, cmd_ready=1.
REQ-037 FF followed by 16 bytes 00 (MAX=16) -> 16 pushes, 17th byte not pushed, frame_error pulse, fifo_clear pulse, state IDLE.
REQ-038 In READY, drive rx byte 55 -> no push, rx_overrun pulse; then cmd_processed=1 -> cmd_processed_received=1 until cmd_processed=0, then fifo_clear one cycle.
REQ-039 With macro, TIMEOUT_CYCLES=100: FF 01 then silence -> frame_error at cycle 100 after last byte, fifo_clear; without macro no error after 1000 cycles.
REQ-040 rst=0 asserted mid-COLLECT after FF 01 -> all outputs 0 asynchronously; after release, FF 02 EE frames normally with frame_bytes=3.
